display_scanner: RTL

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner_if.sv | 22 ++
 rtl/display_scanner.sv | 107 ++++++++++
 2 files changed

// File: rtl/display_scanner_if.sv
// Bundles the display-scanner control, load handshake and digit-drive signals.
// The bench drives through the master modport; the scanner uses the slave modport.
interface display_scanner_if;
  logic        enable;
  logic        load;
  logic [15:0] data;
  logic        load_ready;
  logic [3:0]  number;
  logic [3:0]  digit_en;
  logic        blank;
  logic        frame_start;

  modport master (
    output enable, load, data,
    input  load_ready, number, digit_en, blank, frame_start
  );

  modport slave (
    input  enable, load, data,
    output load_ready, number, digit_en, blank, frame_start
  );
endinterface

// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner with a double-buffered frame register.
// Define DISPLAY_LZB_EN to add leading-zero blanking on digits 3..1.
module display_scanner #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset_n,
  display_scanner_if.slave  bus
);

  localparam int unsigned   PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   shadow;
  logic          pending;

  logic          tick;
  logic          wrap;
  logic          accept;
  logic          pending_next;

  logic [3:0]    number_q;
  logic [3:0]    digit_en_q;
  logic          frame_start_q;
  logic          load_ready_q;

  always_comb begin
    tick         = bus.enable && (presc == LAST);
    wrap         = tick && (idx == 2'd3);
    accept       = bus.load && load_ready_q;
    // accept is only possible with pending clear, so it never races the copy.
    pending_next = accept || (pending && !wrap);
  end

  // NOTE: every flop uses non-blocking assignment and the async active-low reset,
  // so all registers in this file update together on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (bus.enable) begin
      if (tick) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= 16'h0000;
      active  <= 16'h0000;
      pending <= 1'b0;
    end else begin
      if (accept) begin
        shadow <= bus.data;
      end else if (wrap && pending) begin
        active <= shadow;
      end
      pending <= pending_next;
    end
  end

  // Outputs are registered from the current digit state, so each digit is
  // presented for exactly the SCAN_DIV edges during which idx holds it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      number_q      <= 4'h0;
      digit_en_q    <= 4'b1111;
      frame_start_q <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      number_q      <= active[{idx, 2'b00} +: 4];
      digit_en_q    <= bus.enable ? ~(4'b0001 << idx) : 4'b1111;
      frame_start_q <= wrap;
      load_ready_q  <= !pending_next;
    end
  end

`ifdef DISPLAY_LZB_EN
  logic blank_q;

  // A digit is blank when it and every more significant nibble are zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= (idx != 2'd0) && ((active >> {idx, 2'b00}) == 16'h0000);
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = 1'b0;
`endif

  assign bus.number      = number_q;
  assign bus.digit_en    = digit_en_q;
  assign bus.frame_start = frame_start_q;
  assign bus.load_ready  = load_ready_q;

endmodule
